// File: rtl/vga_fb_scanout.sv
// VGA 640x480@60 scan-out of a 320x240 RGB332 framebuffer, pixel- and line-doubled.
// Define VGA_FB_TEST_PATTERN_EN to replace framebuffer pixels with 8 vertical colour bars.
module vga_fb_scanout #(
  parameter int          CLK_DIV  = 2,
  parameter logic [31:0] FB_BASE  = 32'h0,
  parameter int          FB_WIDTH = 320,
  parameter int          H_VIS    = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_VIS    = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [7:0]  i_PixelData,
  output logic [31:0] o_RdAddr,
  output logic        o_HS,
  output logic        o_VS,
  output logic [3:0]  o_RED,
  output logic [3:0]  o_GREEN,
  output logic [3:0]  o_BLUE
);

  localparam int               H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int               V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0]       H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0]       V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0]       HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0]       HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]       VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0]       VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [31:0]      FB_W32   = 32'(FB_WIDTH);

  function automatic logic [11:0] rgb332_expand(input logic [7:0] p);
    return {p[7:5], p[7], p[4:2], p[4], p[1:0], p[1:0]};
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic             vis_p0, hs_p0, vs_p0;
  logic [31:0]      addr_p0;
  logic             vis_p1_q, hs_p1_q, vs_p1_q;
  logic [11:0]      src_rgb_p1, rgb_p1;

  assign pix_en = (div_q == DIV_LAST);

  always_comb begin
    div_d   = pix_en ? '0 : div_q + 1'b1;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // stage p0: raster position decode and framebuffer address
  assign vis_p0  = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
  assign hs_p0   = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
  assign vs_p0   = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
  assign addr_p0 = vis_p0 ? (FB_BASE + ({23'd0, v_cnt_q[9:1]} * FB_W32) + {23'd0, h_cnt_q[9:1]})
                          : FB_BASE;

  // stage p1: pixel source, aligned with the delayed sync/visible flags
`ifdef VGA_FB_TEST_PATTERN_EN
  function automatic logic [11:0] bar_rgb(input logic [9:0] h);
    logic [2:0] idx;
    idx = 3'd7;
    for (int b = 6; b >= 0; b--) begin
      if (h < 10'((b + 1) * 80)) idx = 3'(b);
    end
    return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
  endfunction

  logic [11:0] bar_p1_q;

  always_ff @(posedge i_CLK) begin
    if (pix_en) bar_p1_q <= bar_rgb(h_cnt_q);
  end

  assign src_rgb_p1 = bar_p1_q;
`else
  logic       cap_en_q;
  logic [7:0] pix_q;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) cap_en_q <= 1'b0;
    else       cap_en_q <= pix_en;
  end

  // RAM data for the address issued on the previous clock is valid only now
  always_ff @(posedge i_CLK) begin
    if (cap_en_q) pix_q <= i_PixelData;
  end

  assign src_rgb_p1 = rgb332_expand(pix_q);
`endif

  assign rgb_p1 = vis_p1_q ? src_rgb_p1 : 12'h000;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      div_q    <= '0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      o_RdAddr <= FB_BASE;
      vis_p1_q <= 1'b0;
      hs_p1_q  <= 1'b1;
      vs_p1_q  <= 1'b1;
      o_HS     <= 1'b1;
      o_VS     <= 1'b1;
      o_RED    <= 4'h0;
      o_GREEN  <= 4'h0;
      o_BLUE   <= 4'h0;
    end else begin
      div_q   <= div_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      if (pix_en) begin
        o_RdAddr <= addr_p0;
        vis_p1_q <= vis_p0;
        hs_p1_q  <= hs_p0;
        vs_p1_q  <= vs_p0;
        // stage p2: registered pins
        o_HS                     <= hs_p1_q;
        o_VS                     <= vs_p1_q;
        {o_RED, o_GREEN, o_BLUE} <= rgb_p1;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Self-checking bench for vga_fb_scanout: raster-position model plus hand-computed pins.
`timescale 1ns/1ps
module tb_vga_fb_scanout;

  localparam int CLK_DIV  = 2;
  localparam int FB_WIDTH = 320;
  localparam int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
  localparam int V_VIS = 4,   V_FP = 2,  V_SYNC = 2,  V_BP = 2;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pix = 8'h00;
  logic [31:0] rd_addr;
  logic        hs, vs;
  logic [3:0]  red, green, blue;

  int n_chk  = 0;
  int n_fail = 0;
  int t;
  int cyc = 0;
  bit ff_mode = 1'b0;

  vga_fb_scanout #(
    .CLK_DIV(CLK_DIV), .FB_BASE(32'h0), .FB_WIDTH(FB_WIDTH),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .i_PixelData(pix), .o_RdAddr(rd_addr),
    .o_HS(hs), .o_VS(vs), .o_RED(red), .o_GREEN(green), .o_BLUE(blue)
  );

  always #5 clk = ~clk;

  // clocks since reset release; pixel tick k lands on clock k*CLK_DIV
  always @(posedge clk or posedge rst) begin
    if (rst) t <= 0;
    else     t <= t + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (ff_mode) return 8'hFF;
    if (a == 32'd0) return 8'hE0;
    if (a == 32'd1) return 8'h1C;
    return 8'(a * 29 + (a >> 5) + 7);
  endfunction

  function automatic bit pos_visible(input int p);
    return ((p % H_TOT) < H_VIS) && ((p / H_TOT) < V_VIS);
  endfunction

  function automatic int model_addr(input int p);
    if (!pos_visible(p)) return 0;
    return ((p / H_TOT) / 2) * FB_WIDTH + (p % H_TOT) / 2;
  endfunction

  function automatic logic [11:0] model_rgb(input int p);
    int h, r3, g3, b2, idx;
    logic [7:0] b;
    h = p % H_TOT;
    if (!pos_visible(p)) return 12'h000;
`ifdef VGA_FB_TEST_PATTERN_EN
    idx = h / 80;
    return {((idx / 4) % 2 == 1) ? 4'hF : 4'h0,
            ((idx / 2) % 2 == 1) ? 4'hF : 4'h0,
            (idx % 2 == 1)       ? 4'hF : 4'h0};
`else
    b  = mem_byte(32'(model_addr(p)));
    r3 = int'(b) / 32;
    g3 = (int'(b) / 4) % 8;
    b2 = int'(b) % 4;
    return {4'(r3 * 2 + r3 / 4), 4'(g3 * 2 + g3 / 4), 4'(b2 * 5)};
`endif
  endfunction

  function automatic logic model_hs(input int p);
    int h;
    h = p % H_TOT;
    return !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
  endfunction

  function automatic logic model_vs(input int p);
    int v;
    v = p / H_TOT;
    return !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
  endfunction

  // framebuffer RAM: valid data only in the cycle after an address is issued
  always @(negedge clk) begin
    if (ff_mode)                                    pix = 8'hFF;
    else if (!rst && t > 0 && (t % CLK_DIV) == 0)  pix = mem_byte(rd_addr);
    else                                            pix = 8'($urandom);
  end

  always @(negedge clk) begin : cmp
    logic [31:0] ea;
    logic        ehs, evs;
    logic [11:0] ergb;
    int          n;
    if (rst) begin
      ea = 32'd0; ehs = 1'b1; evs = 1'b1; ergb = 12'h000;
    end else begin
      n  = t / CLK_DIV;
      ea = (n == 0) ? 32'd0 : 32'(model_addr((n - 1) % FRAME));
      if (n < 2) begin
        ehs = 1'b1; evs = 1'b1; ergb = 12'h000;
      end else begin
        ehs  = model_hs((n - 2) % FRAME);
        evs  = model_vs((n - 2) % FRAME);
        ergb = model_rgb((n - 2) % FRAME);
      end
    end
    check("model_cycle", {rd_addr, hs, vs, red, green, blue}, {ea, ehs, evs, ergb});
  end

  logic hs_prev = 1'b1, vs_prev = 1'b1;
  int   hs_fall = -1, vs_fall = -1;
  bit   hs_w_done = 0, hs_p_done = 0, vs_w_done = 0, vs_p_done = 0;

  always @(negedge clk) begin : sync_meas
    if (!rst) begin
      if (hs_prev && !hs) begin
        if (hs_fall >= 0 && !hs_p_done) begin check("hs_period", 64'(cyc - hs_fall), 64'd1600); hs_p_done = 1; end
        hs_fall = cyc;
      end
      if (!hs_prev && hs && hs_fall >= 0 && !hs_w_done) begin
        check("hs_width", 64'(cyc - hs_fall), 64'd192); hs_w_done = 1;
      end
      if (vs_prev && !vs) begin
        if (vs_fall >= 0 && !vs_p_done) begin check("vs_period", 64'(cyc - vs_fall), 64'd16000); vs_p_done = 1; end
        vs_fall = cyc;
      end
      if (!vs_prev && vs && vs_fall >= 0 && !vs_w_done) begin
        check("vs_width", 64'(cyc - vs_fall), 64'd3200); vs_w_done = 1;
      end
    end
    hs_prev = hs;
    vs_prev = vs;
  end

  // return on the negedge after o_RdAddr is loaded with the address for (h,v)
  task automatic wait_addr_pos(input int h, input int v);
    bit found = 0;
    for (int k = 0; k < 40000 && !found; k++) begin
      @(negedge clk);
      if (!rst && t > 0 && (t % CLK_DIV) == 0 && ((t / CLK_DIV - 1) % FRAME) == v * H_TOT + h) found = 1;
    end
    if (!found) check("wait_addr_timeout", 64'd0, 64'd1);
  endtask

  // return on the negedge after the pins show raster position (h,v)
  task automatic wait_out_pos(input int h, input int v);
    bit found = 0;
    for (int k = 0; k < 40000 && !found; k++) begin
      @(negedge clk);
      if (!rst && t >= 2 * CLK_DIV && (t % CLK_DIV) == 0 && ((t / CLK_DIV - 2) % FRAME) == v * H_TOT + h) found = 1;
    end
    if (!found) check("wait_out_timeout", 64'd0, 64'd1);
  endtask

  // return on the negedge after the raster counters reach (h,v)
  task automatic wait_cnt_pos(input int h, input int v);
    bit found = 0;
    for (int k = 0; k < 40000 && !found; k++) begin
      @(negedge clk);
      if (!rst && t > 0 && (t % CLK_DIV) == 0 && ((t / CLK_DIV) % FRAME) == v * H_TOT + h) found = 1;
    end
    if (!found) check("wait_cnt_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_addr", rd_addr, 32'd0);
    check("rst_hs", hs, 1'b1);
    check("rst_vs", vs, 1'b1);
    check("rst_rgb", {red, green, blue}, 12'h000);
    @(negedge clk);
    rst = 1'b0;

`ifndef VGA_FB_TEST_PATTERN_EN
    wait_out_pos(0, 0);  check("px0_rgb", {red, green, blue}, 12'hF00);
    wait_out_pos(1, 0);  check("px1_rgb", {red, green, blue}, 12'hF00);
    check("addr_h2", rd_addr, 32'd1);
    wait_out_pos(2, 0);  check("px2_rgb", {red, green, blue}, 12'h0F0);
    wait_out_pos(3, 0);  check("px3_rgb", {red, green, blue}, 12'h0F0);
`endif
    wait_addr_pos(638, 0); check("addr_638_0", rd_addr, 32'd319);
    wait_addr_pos(639, 0); check("addr_639_0", rd_addr, 32'd319);
    wait_addr_pos(640, 0); check("addr_640_0", rd_addr, 32'd0);
    wait_out_pos(640, 0);  check("rgb_640_0", {red, green, blue}, 12'h000);
    wait_addr_pos(0, 1);   check("addr_0_1", rd_addr, 32'd0);
    wait_addr_pos(639, 1); check("addr_639_1", rd_addr, 32'd319);
    wait_addr_pos(0, 2);   check("addr_0_2", rd_addr, 32'd320);
    wait_addr_pos(639, 3); check("addr_last", rd_addr, 32'd639);

    wait_out_pos(0, 5);
    ff_mode = 1'b1;
    wait_out_pos(700, 5);  check("hs_low_700", hs, 1'b0);
    check("rgb_blank_700", {red, green, blue}, 12'h000);
`ifndef VGA_FB_TEST_PATTERN_EN
    wait_out_pos(0, 0);    check("ff_first", {red, green, blue}, 12'hFFF);
    wait_out_pos(639, 3);  check("ff_last", {red, green, blue}, 12'hFFF);
`endif
    wait_out_pos(640, 3);  check("ff_hblank", {red, green, blue}, 12'h000);
    wait_out_pos(0, 4);    check("ff_vblank", {red, green, blue}, 12'h000);

    wait_cnt_pos(300, 1);
    check("pre_rst_addr", rd_addr, 32'd149);
    #1 rst = 1'b1;
    #1;
    check("async_rst_addr", rd_addr, 32'd0);
    check("async_rst_hs", hs, 1'b1);
    check("async_rst_vs", vs, 1'b1);
    check("async_rst_rgb", {red, green, blue}, 12'h000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
`ifndef VGA_FB_TEST_PATTERN_EN
    wait_out_pos(0, 0);    check("restart_rgb", {red, green, blue}, 12'hFFF);
`endif
    wait_out_pos(2, 0);    check("restart_addr", rd_addr, 32'd1);
    repeat (2000) @(posedge clk);

    check("hs_measured", {hs_w_done, hs_p_done}, 2'b11);
    check("vs_measured", {vs_w_done, vs_p_done}, 2'b11);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
